// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// The BREAK state exists only when UART_RX_BREAK_DET_EN is defined.
package uart_rx_pkg;

    localparam int EDGE_CNT_W = 6;
    localparam int BIT_CNT_W  = 4;

    // Sampler window half-width around MID, and strobe offset past MID.
    localparam logic [EDGE_CNT_W-1:0] SAMP_HALF = 6'd1;
    localparam logic [EDGE_CNT_W-1:0] STRB_OFS  = 6'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
`ifdef UART_RX_BREAK_DET_EN
        , ST_BREAK
`endif
    } uart_rx_state_t;

    function automatic logic [EDGE_CNT_W-1:0] mid_edge(input int unsigned prescale);
        return EDGE_CNT_W'(prescale / 2);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: drives the edge/bit counter and strobes the datapath.
// Optional break detection (BREAK state, break_det port) under UART_RX_BREAK_DET_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic [EDGE_CNT_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  sampled_bit,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  cnt_en,
    output logic                  cnt_clr,
    output logic                  samp_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic [1:0]            frame_err
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                  break_det
`endif
);

    localparam logic [EDGE_CNT_W-1:0] MID    = mid_edge(PRESCALE);
    localparam logic [EDGE_CNT_W-1:0] LAST_E = EDGE_CNT_W'(PRESCALE - 1);
    localparam logic [EDGE_CNT_W-1:0] STRB_E = MID + STRB_OFS;
    localparam logic [BIT_CNT_W-1:0]  LAST_B = BIT_CNT_W'(DATA_WIDTH);

    uart_rx_state_t r_state;
    logic           r_par_en;
    logic           r_par_cap;
    logic           r_stp_cap;
    logic           r_par_chk_d;
    logic           r_stp_chk_d;

    logic w_last;
    logic w_strb;
    logic w_stp_now;

    assign w_last    = (edge_cnt == LAST_E);
    assign w_strb    = (edge_cnt == STRB_E);
    // Stop result lands on the same edge as STOP's LAST, so look through the capture.
    assign w_stp_now = r_stp_cap | (r_stp_chk_d & stp_err);

    always_comb begin
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        deser_en   = 1'b0;
        par_chk_en = 1'b0;
        stp_chk_en = 1'b0;
        case (r_state)
            ST_START:  cnt_en = 1'b1;
            ST_DATA:   begin cnt_en = 1'b1; deser_en   = w_strb; end
            ST_PARITY: begin cnt_en = 1'b1; par_chk_en = w_strb; end
            ST_STOP:   begin cnt_en = 1'b1; stp_chk_en = w_strb; end
            default:   cnt_clr = 1'b1;
        endcase
        samp_en = cnt_en && (edge_cnt >= MID - SAMP_HALF) && (edge_cnt <= MID + SAMP_HALF);
    end

`ifdef UART_RX_BREAK_DET_EN
    assign break_det = (r_state == ST_BREAK);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_par_en    <= 1'b0;
            r_par_cap   <= 1'b0;
            r_stp_cap   <= 1'b0;
            r_par_chk_d <= 1'b0;
            r_stp_chk_d <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 2'b00;
        end else begin
            data_valid  <= 1'b0;
            r_par_chk_d <= par_chk_en;
            r_stp_chk_d <= stp_chk_en;
            if (r_par_chk_d) r_par_cap <= par_err & r_par_en;
            if (r_stp_chk_d) r_stp_cap <= stp_err;
            case (r_state)
                ST_IDLE: begin
                    if (!rx_in) begin
                        r_state   <= ST_START;
                        r_par_en  <= par_en;
                        r_par_cap <= 1'b0;
                        r_stp_cap <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_last) r_state <= sampled_bit ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_last && bit_cnt == LAST_B) r_state <= r_par_en ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (w_last) r_state <= ST_STOP;
                end
                ST_STOP: begin
`ifdef UART_RX_BREAK_DET_EN
                    if (w_last) r_state <= (w_stp_now && !rx_in) ? ST_BREAK : ST_DONE;
`else
                    if (w_last) r_state <= ST_DONE;
`endif
                end
                ST_DONE: begin
                    frame_err  <= {r_stp_cap, r_par_cap};
                    data_valid <= ~(r_stp_cap | r_par_cap);
                    if (!rx_in) begin
                        r_state   <= ST_START;
                        r_par_en  <= par_en;
                        r_par_cap <= 1'b0;
                        r_stp_cap <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                ST_BREAK: begin
                    if (rx_in) begin
                        r_state   <= ST_IDLE;
                        frame_err <= {r_stp_cap, r_par_cap};
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
